// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: state encoding and word-slot constants shared by operand_loader
package operand_loader_pkg;
    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} opl_state_e;
    localparam int OPL_WORDS = 6;
    localparam int OPL_WIDX_W = 3;
    localparam logic [OPL_WIDX_W-1:0] OPL_D1    = 3'd0;
    localparam logic [OPL_WIDX_W-1:0] OPL_D2    = 3'd1;
    localparam logic [OPL_WIDX_W-1:0] OPL_D3_LO = 3'd2;
    localparam logic [OPL_WIDX_W-1:0] OPL_D3_HI = 3'd3;
    localparam logic [OPL_WIDX_W-1:0] OPL_D4_LO = 3'd4;
    localparam logic [OPL_WIDX_W-1:0] OPL_D4_HI = 3'd5;
endpackage

// File: rtl/opl_watchdog.sv
// opl_watchdog: counts RUN cycles and flags expiry at TIMEOUT_CYCLES-1 unless done arrives
module opl_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic done,
    output logic expire
);
    logic [15:0] cnt;
    always_ff @(posedge clk) cnt <= (rst || !run) ? 16'd0 : cnt + 16'd1;
    assign expire = run && !done && cnt == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/operand_loader.sv
// operand_loader: packs six 16-bit words into four operands and holds start until done; watchdog under OPERAND_LOADER_TIMEOUT_EN
module operand_loader import operand_loader_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] data_in1,
    output logic [15:0] data_in2,
    output logic [31:0] data_in3,
    output logic [31:0] data_in4,
    output logic        start,
    input  logic        done,
    output logic        busy,
    output logic        timeout
);
    opl_state_e state;
    logic [OPL_WIDX_W-1:0] widx;
    logic expire;
`ifdef OPERAND_LOADER_TIMEOUT_EN
    opl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk(clk), .rst(rst), .run(state == RUN), .done(done), .expire(expire)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif
    assign in_ready = state == LOAD && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            widx     <= '0;
            data_in1 <= '0;
            data_in2 <= '0;
            data_in3 <= '0;
            data_in4 <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (state == LOAD) begin
                if (in_valid) begin
                    case (widx)
                        OPL_D1:    data_in1        <= in_data;
                        OPL_D2:    data_in2        <= in_data;
                        OPL_D3_LO: data_in3[15:0]  <= in_data;
                        OPL_D3_HI: data_in3[31:16] <= in_data;
                        OPL_D4_LO: data_in4[15:0]  <= in_data;
                        OPL_D4_HI: data_in4[31:16] <= in_data;
                        default: ;
                    endcase
                    widx <= widx == OPL_WIDX_W'(OPL_WORDS - 1) ? '0 : widx + 1'b1;
                    if (widx == OPL_WIDX_W'(OPL_WORDS - 1)) begin
                        state <= RUN;
                        start <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
            end else if (done || expire) begin
                state <= LOAD;
                start <= 1'b0;
                busy  <= 1'b0;
            end
        end
    end
endmodule
